// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-port-side signals of the memory port arbiter.
// master = arbiter view, slave = view of the requesters and memory controller.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              boot_done;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_cmd_en;
  logic [2:0]        mem_cmd_instr;
  logic [5:0]        mem_cmd_bl;
  logic [ADDR_W-1:0] mem_cmd_byte_addr;
  logic              mem_cmd_full;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [3:0]        mem_wr_mask;
  logic              mem_wr_full;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_empty;
  logic              mem_rd_error;

  modport master (
    input  boot_done, i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_cmd_full, mem_wr_full, mem_rd_data, mem_rd_empty, mem_rd_error,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_data, mem_wr_mask, mem_rd_en
  );

  modport slave (
    output boot_done, i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_cmd_full, mem_wr_full, mem_rd_data, mem_rd_empty, mem_rd_error,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_data, mem_wr_mask, mem_rd_en
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-word memory user port between the
// fetch unit (I, read only) and the load/store unit (D); one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [2:0] INSTR_RD = 3'b001;
  localparam logic [2:0] INSTR_WR = 3'b000;

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_CMD, S_WAIT, S_READ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              gnt_d_q, gnt_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              i_done_q, i_done_d, i_err_q, i_err_d;
  logic              d_done_q, d_done_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              cmd_en_q, cmd_en_d;
  logic [2:0]        cmd_instr_q, cmd_instr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [3:0]        wr_mask_q, wr_mask_d;
  logic              rd_en_q, rd_en_d;
  logic              pick_d, finish, fail, load_rdata;
  logic [DATA_W-1:0] rdata_new;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    gnt_d_d     = gnt_d_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    cmd_en_d    = 1'b0;
    cmd_instr_d = cmd_instr_q;
    cmd_addr_d  = cmd_addr_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    rd_en_d     = 1'b0;
    pick_d      = 1'b0;
    finish      = 1'b0;
    fail        = 1'b0;
    load_rdata  = 1'b0;
    rdata_new   = '0;

    unique case (state_q)
      S_IDLE: begin
        // empty lags a pop by one cycle, so skip the cycle after a drain pulse
        if (!bus.mem_rd_empty) begin
          rd_en_d = !rd_en_q;
        end else if (bus.boot_done && (bus.i_req || bus.d_req)) begin
          pick_d   = bus.d_req && (!bus.i_req || !last_d_q);
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = pick_d && bus.d_we;
          addr_d   = pick_d ? bus.d_addr : bus.i_addr;
          wdata_d  = bus.d_wdata;
          be_d     = bus.d_be;
          state_d  = (pick_d && bus.d_we) ? S_WDATA : S_CMD;
        end
      end
      S_WDATA: begin
        if (!bus.mem_wr_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = wdata_q;
          wr_mask_d = ~be_q;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (!bus.mem_cmd_full) begin
          cmd_en_d    = 1'b1;
          cmd_instr_d = we_q ? INSTR_WR : INSTR_RD;
          cmd_addr_d  = addr_q;
          cnt_d       = '0;
          finish      = we_q;
          state_d     = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.mem_rd_empty) begin
          rd_en_d = 1'b1;
          state_d = S_READ;
        end else if (bus.mem_rd_error || cnt_q == CNT_W'(RD_TIMEOUT)) begin
          finish     = 1'b1;
          fail       = 1'b1;
          load_rdata = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        finish     = 1'b1;
        load_rdata = 1'b1;
        rdata_new  = bus.mem_rd_data;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      if (gnt_d_q) begin
        d_done_d = 1'b1;
        d_err_d  = fail;
        if (load_rdata) d_rdata_d = rdata_new;
      end else begin
        i_done_d = 1'b1;
        i_err_d  = fail;
        if (load_rdata) i_rdata_d = rdata_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b1;
      gnt_d_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      cmd_en_q    <= 1'b0;
      cmd_instr_q <= '0;
      cmd_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      gnt_d_q     <= gnt_d_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      cmd_en_q    <= cmd_en_d;
      cmd_instr_q <= cmd_instr_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign bus.i_done            = i_done_q;
  assign bus.i_err             = i_err_q;
  assign bus.i_rdata           = i_rdata_q;
  assign bus.d_done            = d_done_q;
  assign bus.d_err             = d_err_q;
  assign bus.d_rdata           = d_rdata_q;
  assign bus.mem_cmd_en        = cmd_en_q;
  assign bus.mem_cmd_instr     = cmd_instr_q;
  assign bus.mem_cmd_bl        = '0;
  assign bus.mem_cmd_byte_addr = cmd_addr_q;
  assign bus.mem_wr_en         = wr_en_q;
  assign bus.mem_wr_data       = wr_data_q;
  assign bus.mem_wr_mask       = wr_mask_q;
  assign bus.mem_rd_en         = rd_en_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small read-FIFO model of the memory controller.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 30;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // memory model controls, written only by the main process
  int          resp_delay = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] next_rdata = '0;
  logic [31:0] inject_word = '0;
  int          inject_cnt = 0;

  // read FIFO model: a popped word leaves the head one cycle after the rd_en cycle
  initial begin
    logic [31:0] rd_q[$];
    logic [31:0] pend_word[$];
    int          pend_due[$];
    int          mcyc;
    int          inject_seen;
    bit          pop_pend;
    mcyc = 0;
    inject_seen = 0;
    pop_pend = 1'b0;
    bus.mem_rd_empty = 1'b1;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (pop_pend && rd_q.size() > 0) void'(rd_q.pop_front());
      pop_pend = bus.mem_rd_en;
      if (bus.mem_cmd_en && bus.mem_cmd_instr == 3'b001 && resp_delay >= 0) begin
        pend_word.push_back(use_fixed ? next_rdata : (32'hC0DE_0000 | {16'h0, bus.mem_cmd_byte_addr[15:0]}));
        pend_due.push_back(mcyc + resp_delay);
      end
      while (pend_due.size() > 0 && pend_due[0] <= mcyc) begin
        rd_q.push_back(pend_word.pop_front());
        void'(pend_due.pop_front());
      end
      if (inject_cnt != inject_seen) begin
        rd_q.push_back(inject_word);
        inject_seen = inject_cnt;
      end
      bus.mem_rd_empty = (rd_q.size() == 0);
      bus.mem_rd_data  = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
      mcyc++;
    end
  end

  // observation record, sampled 1 time unit after each rising edge
  int tcyc, n_cmd, n_wr, n_rd, n_idone, n_ddone, both_done;
  int cmd_cyc, wr_cyc, first_rd_cyc, idone_cyc, ddone_cyc;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [2:0]        cmd_instr_s;
  logic [31:0]       wr_data_s, idone_rdata, ddone_rdata;
  logic [3:0]        wr_mask_s;
  logic              idone_err, ddone_err;

  task automatic clear_mon();
    tcyc = 0; n_cmd = 0; n_wr = 0; n_rd = 0; n_idone = 0; n_ddone = 0; both_done = 0;
    cmd_cyc = -1; wr_cyc = -1; first_rd_cyc = -1; idone_cyc = -1; ddone_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
    if (bus.mem_cmd_en) begin
      n_cmd++; cmd_cyc = tcyc; cmd_addr_s = bus.mem_cmd_byte_addr; cmd_instr_s = bus.mem_cmd_instr;
    end
    if (bus.mem_wr_en) begin
      n_wr++; wr_cyc = tcyc; wr_data_s = bus.mem_wr_data; wr_mask_s = bus.mem_wr_mask;
    end
    if (bus.mem_rd_en) begin
      n_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = tcyc;
    end
    if (bus.i_done) begin
      n_idone++; idone_cyc = tcyc; idone_rdata = bus.i_rdata; idone_err = bus.i_err;
    end
    if (bus.d_done) begin
      n_ddone++; ddone_cyc = tcyc; ddone_rdata = bus.d_rdata; ddone_err = bus.d_err;
    end
    if (bus.i_done && bus.d_done) both_done++;
  endtask

  task automatic wait_done(input bit want_d, input int limit, output bit ok);
    int base;
    base = want_d ? n_ddone : n_idone;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if ((want_d ? n_ddone : n_idone) != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] pulses;
    repeat (3) step();
    pulses = {bus.i_done, bus.d_done, bus.i_err, bus.d_err, bus.mem_cmd_en, bus.mem_wr_en, bus.mem_rd_en};
    checks++;
    if (pulses !== 7'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000000", pulses); end
    checks++;
    if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got i=%h d=%h expected 0", bus.i_rdata, bus.d_rdata);
    end
    checks++;
    if (bus.mem_cmd_instr !== 3'b000 || bus.mem_cmd_bl !== 6'd0 || bus.mem_cmd_byte_addr !== '0) begin
      errors++; $display("FAIL reset_cmd: got instr=%b bl=%0d addr=%h expected 0", bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr);
    end
    checks++;
    if (bus.mem_wr_data !== 32'h0 || bus.mem_wr_mask !== 4'h0) begin
      errors++; $display("FAIL reset_wr: got data=%h mask=%b expected 0", bus.mem_wr_data, bus.mem_wr_mask);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_boot_gate_read();
    bit ok;
    bus.boot_done = 1'b0;
    bus.i_addr = 30'h100;
    bus.i_req = 1'b1;
    clear_mon();
    repeat (20) step();
    checks++;
    if (n_cmd != 0 || n_idone != 0) begin
      errors++; $display("FAIL boot_gate: got cmd pulses=%0d i_done=%0d expected 0 0", n_cmd, n_idone);
    end
    use_fixed = 1'b1;
    next_rdata = 32'hDEAD_BEEF;
    resp_delay = 2;
    bus.boot_done = 1'b1;
    clear_mon();
    wait_done(1'b0, 50, ok);
    bus.i_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL read_done_seen: i_done not seen within 50 cycles"); end
    checks++;
    if (idone_rdata !== 32'hDEAD_BEEF || idone_err !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b expected deadbeef err=0", idone_rdata, idone_err);
    end
    checks++;
    if (cmd_cyc != 2 || cmd_instr_s !== 3'b001 || cmd_addr_s !== 30'h100) begin
      errors++; $display("FAIL read_cmd: got cyc=%0d instr=%b addr=%h expected 2 001 100", cmd_cyc, cmd_instr_s, cmd_addr_s);
    end
    checks++;
    if (idone_cyc != 6 || n_ddone != 0) begin
      errors++; $display("FAIL read_latency: got done cyc=%0d d_done=%0d expected 6 0", idone_cyc, n_ddone);
    end
    use_fixed = 1'b0;
    resp_delay = 0;
    step();
  endtask

  task automatic test_write();
    bit ok;
    bus.d_we = 1'b1;
    bus.d_addr = 30'h40;
    bus.d_wdata = 32'h1234_5678;
    bus.d_be = 4'b0011;
    bus.d_req = 1'b1;
    clear_mon();
    wait_done(1'b1, 30, ok);
    bus.d_req = 1'b0;
    checks++;
    if (!ok || ddone_cyc != 3) begin
      errors++; $display("FAIL write_latency: got ok=%0d cyc=%0d expected 1 3", ok, ddone_cyc);
    end
    checks++;
    if (n_wr != 1 || wr_cyc != 2 || wr_data_s !== 32'h1234_5678 || wr_mask_s !== 4'b1100) begin
      errors++; $display("FAIL write_data: got n=%0d cyc=%0d data=%h mask=%b expected 1 2 12345678 1100", n_wr, wr_cyc, wr_data_s, wr_mask_s);
    end
    checks++;
    if (n_cmd != 1 || cmd_cyc != 3 || cmd_instr_s !== 3'b000 || cmd_addr_s !== 30'h40) begin
      errors++; $display("FAIL write_cmd: got n=%0d cyc=%0d instr=%b addr=%h expected 1 3 000 40", n_cmd, cmd_cyc, cmd_instr_s, cmd_addr_s);
    end
    checks++;
    if (n_idone != 0 || ddone_err !== 1'b0 || n_rd != 0) begin
      errors++; $display("FAIL write_side: got i_done=%0d d_err=%b rd=%0d expected 0 0 0", n_idone, ddone_err, n_rd);
    end
    bus.d_we = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    bit ok, exp_d, got_d, got_i;
    int pi, pd, dcyc;
    logic [31:0] obs, expv;
    bus.i_addr = 30'h200;
    bus.d_addr = 30'h300;
    bus.d_we = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      pi = n_idone;
      pd = n_ddone;
      for (int c = 0; c < 30; c++) begin
        step();
        if (n_idone != pi || n_ddone != pd) break;
      end
      ok = (n_idone != pi || n_ddone != pd);
      got_i = (n_idone != pi);
      got_d = (n_ddone != pd);
      exp_d = (k % 2 == 1);
      if (k == 3) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      checks++;
      if (!ok || got_i == got_d || got_d != exp_d) begin
        errors++; $display("FAIL rr_grant_%0d: got i_done=%0d d_done=%0d expected requester %s", k, got_i, got_d, exp_d ? "D" : "I");
      end
      obs = exp_d ? ddone_rdata : idone_rdata;
      expv = exp_d ? 32'hC0DE_0300 : 32'hC0DE_0200;
      dcyc = exp_d ? ddone_cyc : idone_cyc;
      checks++;
      if (obs !== expv || dcyc != 4 + 5 * k) begin
        errors++; $display("FAIL rr_data_%0d: got %h at cyc %0d expected %h at cyc %0d", k, obs, dcyc, expv, 4 + 5 * k);
      end
    end
    checks++;
    if (both_done != 0) begin errors++; $display("FAIL rr_both_done: got %0d expected 0", both_done); end
    step();
  endtask

  task automatic test_cmd_full();
    bit ok;
    bus.i_addr = 30'h80;
    bus.mem_cmd_full = 1'b1;
    bus.i_req = 1'b1;
    clear_mon();
    repeat (6) step();
    bus.mem_cmd_full = 1'b0;
    wait_done(1'b0, 30, ok);
    bus.i_req = 1'b0;
    checks++;
    if (n_cmd != 1 || cmd_cyc != 7) begin
      errors++; $display("FAIL full_cmd: got n=%0d cyc=%0d expected 1 7", n_cmd, cmd_cyc);
    end
    checks++;
    if (!ok || idone_cyc != 9 || idone_rdata !== 32'hC0DE_0080) begin
      errors++; $display("FAIL full_done: got ok=%0d cyc=%0d data=%h expected 1 9 c0de0080", ok, idone_cyc, idone_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    bus.d_addr = 30'h44;
    bus.d_we = 1'b0;
    resp_delay = -1;
    bus.d_req = 1'b1;
    clear_mon();
    wait_done(1'b1, 1100, ok);
    bus.d_req = 1'b0;
    checks++;
    if (!ok || ddone_cyc != RD_TIMEOUT + 3) begin
      errors++; $display("FAIL tmo_latency: got ok=%0d cyc=%0d expected 1 %0d", ok, ddone_cyc, RD_TIMEOUT + 3);
    end
    checks++;
    if (ddone_err !== 1'b1 || ddone_rdata !== 32'h0 || n_idone != 0) begin
      errors++; $display("FAIL tmo_result: got err=%b data=%h i_done=%0d expected 1 0 0", ddone_err, ddone_rdata, n_idone);
    end
    step();
    resp_delay = 0;
    inject_word = 32'h0BAD_F00D;
    inject_cnt++;
    bus.i_addr = 30'h104;
    bus.i_req = 1'b1;
    clear_mon();
    wait_done(1'b0, 40, ok);
    bus.i_req = 1'b0;
    checks++;
    if (first_rd_cyc != 1 || cmd_cyc != 4 || n_rd != 2) begin
      errors++; $display("FAIL tmo_drain: got rd cyc=%0d cmd cyc=%0d rd pulses=%0d expected 1 4 2", first_rd_cyc, cmd_cyc, n_rd);
    end
    checks++;
    if (!ok || idone_cyc != 6 || idone_rdata !== 32'hC0DE_0104 || idone_err !== 1'b0 || bus.d_err !== 1'b0) begin
      errors++; $display("FAIL tmo_next: got ok=%0d cyc=%0d data=%h err=%b expected 1 6 c0de0104 0", ok, idone_cyc, idone_rdata, idone_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [6:0] pulses;
    use_fixed = 1'b1;
    next_rdata = 32'hBAD0_BAD0;
    resp_delay = 4;
    bus.i_addr = 30'h108;
    bus.i_req = 1'b1;
    clear_mon();
    repeat (3) step();
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1;
    pulses = {bus.i_done, bus.d_done, bus.i_err, bus.d_err, bus.mem_cmd_en, bus.mem_wr_en, bus.mem_rd_en};
    checks++;
    if (pulses !== 7'b0 || bus.i_rdata !== 32'h0 || bus.mem_cmd_instr !== 3'b000 || bus.mem_cmd_byte_addr !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got pulses=%b rdata=%h instr=%b addr=%h expected all 0", pulses, bus.i_rdata, bus.mem_cmd_instr, bus.mem_cmd_byte_addr);
    end
    use_fixed = 1'b0;
    resp_delay = 0;
    clear_mon();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (6) step();
    checks++;
    if (n_rd != 1 || n_cmd != 0 || n_idone != 0) begin
      errors++; $display("FAIL rst_mid_drain: got rd=%0d cmd=%0d i_done=%0d expected 1 0 0", n_rd, n_cmd, n_idone);
    end
    bus.i_addr = 30'h10C;
    bus.i_req = 1'b1;
    clear_mon();
    wait_done(1'b0, 30, ok);
    bus.i_req = 1'b0;
    checks++;
    if (!ok || idone_cyc != 4 || idone_rdata !== 32'hC0DE_010C || idone_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_next: got ok=%0d cyc=%0d data=%h err=%b expected 1 4 c0de010c 0", ok, idone_cyc, idone_rdata, idone_err);
    end
    step();
  endtask

  initial begin
    bus.boot_done = 1'b0;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_be = '0;
    bus.mem_cmd_full = 1'b0;
    bus.mem_wr_full = 1'b0;
    bus.mem_rd_error = 1'b0;
    clear_mon();
    test_reset();
    test_boot_gate_read();
    test_write();
    test_round_robin();
    test_cmd_full();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
